// File: rtl/sprite_plotter.sv
// Sprite plotter: erases an object's previous square in background colour, then
// draws it at the new position, emitting one pixel per cycle to the VGA adapter.
module sprite_plotter #(
    parameter int unsigned SPRITE_W  = 4,
    parameter int unsigned SPRITE_H  = 4,
    parameter int unsigned X_MAX     = 159,
    parameter int unsigned Y_MAX     = 119,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       draw_req,
    input  logic [7:0] obj_x,
    input  logic [6:0] obj_y,
    input  logic [2:0] obj_colour,
    output logic       req_ready,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);
    localparam int unsigned CNT_W = $clog2(SPRITE_W * SPRITE_H);
    localparam int unsigned DX_W  = $clog2(SPRITE_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SPRITE_W * SPRITE_H - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ERASE = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [7:0]       r_new_x, w_new_x_nxt, r_old_x, w_old_x_nxt;
    logic [6:0]       r_new_y, w_new_y_nxt, r_old_y, w_old_y_nxt;
    logic [2:0]       r_new_col, w_new_col_nxt;
    logic             r_old_valid, w_old_valid_nxt;

    logic             r_req_ready, r_plot, r_busy, r_done;
    logic [7:0]       r_vga_x, w_vga_x_nxt;
    logic [6:0]       r_vga_y, w_vga_y_nxt;
    logic [2:0]       r_vga_colour, w_vga_colour_nxt;
    logic             w_plot_nxt;

    logic             w_pix;
    logic [CNT_W-1:0] w_dx, w_dy;
    logic [7:0]       w_base_x;
    logic [6:0]       w_base_y;
    logic [8:0]       w_sum_x;
    logic [7:0]       w_sum_y;

    // Next state and the pixel that the next state/count will present.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_new_x_nxt     = r_new_x;
        w_new_y_nxt     = r_new_y;
        w_new_col_nxt   = r_new_col;
        w_old_x_nxt     = r_old_x;
        w_old_y_nxt     = r_old_y;
        w_old_valid_nxt = r_old_valid;

        case (r_state)
            S_IDLE: begin
                if (draw_req) begin
                    w_new_x_nxt   = obj_x;
                    w_new_y_nxt   = obj_y;
                    w_new_col_nxt = obj_colour;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = r_old_valid ? S_ERASE : S_DRAW;
                end
            end
            S_ERASE: begin
                if (r_cnt == LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DRAW;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DRAW: begin
                if (r_cnt == LAST) begin
                    w_state_nxt     = S_DONE;
                    w_old_x_nxt     = r_new_x;
                    w_old_y_nxt     = r_new_y;
                    w_old_valid_nxt = (r_new_col != 3'b000);
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        w_pix    = (w_state_nxt == S_ERASE) || (w_state_nxt == S_DRAW);
        w_dx     = w_cnt_nxt & CNT_W'(SPRITE_W - 1);
        w_dy     = w_cnt_nxt >> DX_W;
        w_base_x = (w_state_nxt == S_ERASE) ? r_old_x : w_new_x_nxt;
        w_base_y = (w_state_nxt == S_ERASE) ? r_old_y : w_new_y_nxt;
        w_sum_x  = {1'b0, w_base_x} + 9'(w_dx);
        w_sum_y  = {1'b0, w_base_y} + 8'(w_dy);

        // Clipped pixels still consume their cycle, only the write-enable drops.
        w_plot_nxt       = w_pix && (w_sum_x <= 9'(X_MAX)) && (w_sum_y <= 8'(Y_MAX));
        w_vga_x_nxt      = w_pix ? w_sum_x[7:0] : r_vga_x;
        w_vga_y_nxt      = w_pix ? w_sum_y[6:0] : r_vga_y;
        w_vga_colour_nxt = r_vga_colour;
        if (w_state_nxt == S_ERASE) begin
            w_vga_colour_nxt = BG_COLOUR;
        end else if (w_state_nxt == S_DRAW) begin
            w_vga_colour_nxt = w_new_col_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_new_x      <= '0;
            r_new_y      <= '0;
            r_new_col    <= '0;
            r_old_x      <= '0;
            r_old_y      <= '0;
            r_old_valid  <= 1'b0;
            r_req_ready  <= 1'b1;
            r_plot       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_new_x      <= w_new_x_nxt;
            r_new_y      <= w_new_y_nxt;
            r_new_col    <= w_new_col_nxt;
            r_old_x      <= w_old_x_nxt;
            r_old_y      <= w_old_y_nxt;
            r_old_valid  <= w_old_valid_nxt;
            r_req_ready  <= (w_state_nxt == S_IDLE);
            r_plot       <= w_plot_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_done       <= (w_state_nxt == S_DONE);
            r_vga_x      <= w_vga_x_nxt;
            r_vga_y      <= w_vga_y_nxt;
            r_vga_colour <= w_vga_colour_nxt;
        end
    end

    assign req_ready  = r_req_ready;
    assign plot       = r_plot;
    assign busy       = r_busy;
    assign done       = r_done;
    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_colour;

endmodule
